// File: rtl/sram_word_arbiter.sv
// Two-requester word arbiter for the byte-wide SRAM A port: each 32-bit request runs as four byte beats.
// Define SRAM_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins); default build is round-robin.
module sram_word_arbiter #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-3:0] wordAddr0,
  input  logic [ADDR_WIDTH-3:0] wordAddr1,
  input  logic [3:0]            byteEn0,
  input  logic [3:0]            byteEn1,
  input  logic [31:0]           wdata0,
  input  logic [31:0]           wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [31:0]           rdata0,
  output logic [31:0]           rdata1,
  output logic                  busy,
  output logic                  grant,
  output logic [ADDR_WIDTH-1:0] sramAddress,
  output logic                  sramWriteEnable,
  output logic [7:0]            sramDataIn,
  input  logic [7:0]            sramDataOut
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DRAIN,
    ST_ACK
  } state_t;

  state_t                r_state;
  logic [1:0]            r_beat;
  logic                  r_grant;
  logic                  r_we;
  logic [ADDR_WIDTH-3:0] r_addr;
  logic [3:0]            r_byteEn;
  logic [31:0]           r_wdata;
  logic [23:0]           r_readBuf;
  logic                  r_ack0;
  logic                  r_ack1;
  logic [31:0]           r_rdata0;
  logic [31:0]           r_rdata1;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_sramAddress;
  logic                  r_sramWe;
  logic [7:0]            r_sramDataIn;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
  logic                  r_lastGrant;
`endif

  logic                  w_anyReq;
  logic                  w_pick;
  logic                  w_we;
  logic [ADDR_WIDTH-3:0] w_addr;
  logic [3:0]            w_byteEn;
  logic [31:0]           w_wdata;
  logic [1:0]            w_nextBeat;
  logic [1:0]            w_prevBeat;

  // Winner selection and the winner's request fields, latched only on the IDLE grant edge.
  always_comb begin
    w_anyReq = req0 | req1;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    w_pick = !req0;
`else
    w_pick = (req0 && req1) ? !r_lastGrant : !req0;
`endif
    w_we       = w_pick ? we1       : we0;
    w_addr     = w_pick ? wordAddr1 : wordAddr0;
    w_byteEn   = w_pick ? byteEn1   : byteEn0;
    w_wdata    = w_pick ? wdata1    : wdata0;
    w_nextBeat = r_beat + 2'd1;
    w_prevBeat = r_beat - 2'd1;
  end

  // SRAM-side outputs are loaded one edge ahead of the beat they drive, so they come straight from flops.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state       <= ST_IDLE;
      r_beat        <= 2'd0;
      r_grant       <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_byteEn      <= 4'd0;
      r_wdata       <= 32'd0;
      r_readBuf     <= 24'd0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_rdata0      <= 32'd0;
      r_rdata1      <= 32'd0;
      r_busy        <= 1'b0;
      r_sramAddress <= '0;
      r_sramWe      <= 1'b0;
      r_sramDataIn  <= 8'd0;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
      r_lastGrant   <= 1'b1;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_state       <= ST_ACCESS;
            r_beat        <= 2'd0;
            r_grant       <= w_pick;
            r_we          <= w_we;
            r_addr        <= w_addr;
            r_byteEn      <= w_byteEn;
            r_wdata       <= w_wdata;
            r_busy        <= 1'b1;
            r_sramAddress <= {w_addr, 2'b00};
            r_sramDataIn  <= w_wdata[7:0];
            r_sramWe      <= w_we & w_byteEn[0];
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
            r_lastGrant   <= w_pick;
`endif
          end
        end
        ST_ACCESS: begin
          // The SRAM returns the previous beat's byte now.
          if (!r_we && r_beat != 2'd0) begin
            r_readBuf[{w_prevBeat, 3'b000} +: 8] <= sramDataOut;
          end
          if (r_beat == 2'd3) begin
            r_state       <= ST_DRAIN;
            r_sramAddress <= '0;
            r_sramWe      <= 1'b0;
            r_sramDataIn  <= 8'd0;
          end else begin
            r_beat        <= w_nextBeat;
            r_sramAddress <= {r_addr, w_nextBeat};
            r_sramDataIn  <= r_wdata[{w_nextBeat, 3'b000} +: 8];
            r_sramWe      <= r_we & r_byteEn[w_nextBeat];
          end
        end
        ST_DRAIN: begin
          if (!r_we) begin
            if (r_grant) begin
              r_rdata1 <= {sramDataOut, r_readBuf};
            end else begin
              r_rdata0 <= {sramDataOut, r_readBuf};
            end
          end
          r_ack0  <= !r_grant;
          r_ack1  <= r_grant;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_beat  <= 2'd0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0            = r_ack0;
  assign ack1            = r_ack1;
  assign rdata0          = r_rdata0;
  assign rdata1          = r_rdata1;
  assign busy            = r_busy;
  assign grant           = r_grant;
  assign sramAddress     = r_sramAddress;
  assign sramWriteEnable = r_sramWe;
  assign sramDataIn      = r_sramDataIn;

endmodule

// File: tb/tb_sram_word_arbiter.sv
// Self-checking bench for sram_word_arbiter: transaction-level model compared every cycle plus literal checks.
// Honours SRAM_ARB_FIXED_PRIORITY_EN when deciding the expected grant order.
module tb_sram_word_arbiter;

  logic        clock;
  logic        resetN;
  logic        req0, req1, we0, we1;
  logic [8:0]  wordAddr0, wordAddr1;
  logic [3:0]  byteEn0, byteEn1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        busy, grant;
  logic [10:0] sramAddress;
  logic        sramWriteEnable;
  logic [7:0]  sramDataIn;
  logic [7:0]  sramDataOut;

  logic [7:0]  sramMem [0:2047];
  logic        memClear;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busyCycles = 0;
  int ackOwner[$];

  // Model state: remaining cycles of the current transaction (6 = beat 0 cycle .. 1 = ack cycle).
  int          mCount = 0;
  bit          mValid = 0;
  bit          mLast = 1;
  bit          mOwner;
  bit          mWe;
  logic [8:0]  mAddr;
  logic [3:0]  mBe;
  logic [31:0] mWdata;
  logic [31:0] mRdata0, mRdata1;
  logic [7:0]  modelMem [0:2047];

  sram_word_arbiter #(.ADDR_WIDTH(11)) dut (
    .clock(clock), .resetN(resetN),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wordAddr0(wordAddr0), .wordAddr1(wordAddr1),
    .byteEn0(byteEn0), .byteEn1(byteEn1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .grant(grant),
    .sramAddress(sramAddress), .sramWriteEnable(sramWriteEnable),
    .sramDataIn(sramDataIn), .sramDataOut(sramDataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read SRAM port with one cycle of latency.
  always @(posedge clock) begin
    if (memClear) begin
      for (int i = 0; i < 2048; i++) sramMem[i] <= 8'h00;
    end else if (sramWriteEnable) begin
      sramMem[sramAddress] <= sramDataIn;
    end
    sramDataOut <= sramMem[sramAddress];
  end

  function void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Transaction-level model: grant decision, byte writes per beat, whole-word read result at the ack.
  initial begin
    int k;
    bit pick;
    for (int i = 0; i < 2048; i++) modelMem[i] = 8'h00;
    forever begin
      @(posedge clock);
      cyc++;
      if (mCount >= 3 && mCount <= 6) begin
        k = 6 - mCount;
        if (mWe && mBe[k]) modelMem[{mAddr, k[1:0]}] = mWdata[8*k +: 8];
      end
      if (!resetN) begin
        mCount = 0; mLast = 1; mRdata0 = 0; mRdata1 = 0; mValid = 1;
      end else if (mCount == 0) begin
        if (req0 || req1) begin
          if (req0 && req1) begin
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
            pick = 0;
`else
            pick = !mLast;
`endif
          end else begin
            pick = req1;
          end
          mLast = pick; mOwner = pick; mCount = 6;
          mWe    = pick ? we1 : we0;
          mAddr  = pick ? wordAddr1 : wordAddr0;
          mBe    = pick ? byteEn1 : byteEn0;
          mWdata = pick ? wdata1 : wdata0;
        end
      end else begin
        if (mCount == 2 && !mWe) begin
          if (mOwner) mRdata1 = {modelMem[{mAddr,2'd3}], modelMem[{mAddr,2'd2}], modelMem[{mAddr,2'd1}], modelMem[{mAddr,2'd0}]};
          else        mRdata0 = {modelMem[{mAddr,2'd3}], modelMem[{mAddr,2'd2}], modelMem[{mAddr,2'd1}], modelMem[{mAddr,2'd0}]};
        end
        mCount--;
      end
    end
  end

  // Compare every cycle at the falling edge, away from the DUT's active edge.
  initial begin
    int k;
    forever begin
      @(negedge clock);
      if (busy) busyCycles++;
      if (ack0) ackOwner.push_back(0);
      if (ack1) ackOwner.push_back(1);
      if (mValid) begin
        k = 6 - mCount;
        checkOutput("busy", busy, mCount > 0);
        checkOutput("ack0", ack0, mCount == 1 && !mOwner);
        checkOutput("ack1", ack1, mCount == 1 && mOwner);
        checkOutput("rdata0", rdata0, mRdata0);
        checkOutput("rdata1", rdata1, mRdata1);
        if (mCount > 0) checkOutput("grant", grant, mOwner);
        if (mCount >= 3 && mCount <= 6) begin
          checkOutput("sramAddress", sramAddress, {mAddr, k[1:0]});
          checkOutput("sramWriteEnable", sramWriteEnable, mWe & mBe[k]);
          checkOutput("sramDataIn", sramDataIn, mWdata[8*k +: 8]);
        end else begin
          checkOutput("sramAddressIdle", sramAddress, 0);
          checkOutput("sramWriteEnableIdle", sramWriteEnable, 0);
          checkOutput("sramDataInIdle", sramDataIn, 0);
        end
      end
    end
  end

  // Requester: raise req, hold it across nTxn acks, drop it in the cycle after the last ack.
  task automatic applyStimulus(input int idx, input bit we, input logic [8:0] addr,
                               input logic [3:0] be, input logic [31:0] wd,
                               input int nTxn, output int lastAck);
    lastAck = -1;
    if (idx == 0) begin we0 = we; wordAddr0 = addr; byteEn0 = be; wdata0 = wd; req0 = 1; end
    else          begin we1 = we; wordAddr1 = addr; byteEn1 = be; wdata1 = wd; req1 = 1; end
    for (int t = 0; t < nTxn; t++) begin
      bit got = 0;
      int waited = 0;
      while (!got && waited < 200) begin
        @(negedge clock);
        waited++;
        if ((idx == 0 && ack0) || (idx == 1 && ack1)) got = 1;
      end
      checkOutput(idx == 0 ? "ack0Arrives" : "ack1Arrives", got, 1);
      lastAck = cyc + 1;
    end
    @(negedge clock);
    if (idx == 0) req0 = 0; else req1 = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int aStart, aAck, bAck;
    int expOrder[4];
    int n0, n1;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    expOrder = '{0, 0, 0, 1}; n0 = 3; n1 = 1;
`else
    expOrder = '{0, 1, 0, 1}; n0 = 2; n1 = 2;
`endif
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    wordAddr0 = 0; wordAddr1 = 0; byteEn0 = 0; byteEn1 = 0; wdata0 = 0; wdata1 = 0;
    resetN = 0; memClear = 1;
    repeat (3) @(negedge clock);
    resetN = 1; memClear = 0;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetRdata0", rdata0, 0);
    checkOutput("resetRdata1", rdata1, 0);

    // Full-word write, then check byte placement, ack latency and busy length.
    busyCycles = 0;
    aStart = cyc;
    applyStimulus(0, 1, 9'h005, 4'b1111, 32'hDEADBEEF, 1, aAck);
    checkOutput("ackLatency", aAck - (aStart + 1), 6);
    checkOutput("busyCycles", busyCycles, 6);
    checkOutput("sram014", sramMem[11'h014], 8'hEF);
    checkOutput("sram015", sramMem[11'h015], 8'hBE);
    checkOutput("sram016", sramMem[11'h016], 8'hAD);
    checkOutput("sram017", sramMem[11'h017], 8'hDE);

    applyStimulus(1, 0, 9'h005, 4'b0000, 32'h0, 1, aAck);
    checkOutput("readBack1", rdata1, 32'hDEADBEEF);
    checkOutput("rdata0Untouched", rdata0, 32'h0);

    // Partial byte-enable write, then read it back.
    applyStimulus(0, 1, 9'h005, 4'b0101, 32'h11223344, 1, aAck);
    applyStimulus(0, 0, 9'h005, 4'b0000, 32'h0, 1, aAck);
    checkOutput("partialWrite", rdata0, 32'hDE22BE44);
    checkOutput("rdata1Held", rdata1, 32'hDEADBEEF);

    // Request arriving while busy waits for the next IDLE sample.
    fork
      applyStimulus(0, 0, 9'h005, 4'b0000, 32'h0, 1, aAck);
      begin
        repeat (2) @(negedge clock);
        applyStimulus(1, 0, 9'h005, 4'b0000, 32'h0, 1, bAck);
      end
    join
    checkOutput("pendingGap", bAck - aAck, 7);
    checkOutput("pendingRead1", rdata1, 32'hDE22BE44);

    // Reset during beat 1 of a write aborts it.
    we0 = 1; wordAddr0 = 9'h010; byteEn0 = 4'b1111; wdata0 = 32'hA1B2C3D4; req0 = 1;
    @(negedge clock);
    @(negedge clock);
    resetN = 0; req0 = 0;
    @(negedge clock);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortAck0", ack0, 0);
    checkOutput("abortRdata0", rdata0, 0);
    resetN = 1;
    @(negedge clock);
    checkOutput("sram040", sramMem[11'h040], 8'hD4);
    checkOutput("sram041", sramMem[11'h041], 8'hC3);
    checkOutput("sram042", sramMem[11'h042], 8'h00);
    checkOutput("sram043", sramMem[11'h043], 8'h00);

    // Both requesters held high from a fresh reset.
    ackOwner.delete();
    fork
      applyStimulus(0, 0, 9'h005, 4'b0000, 32'h0, n0, aAck);
      applyStimulus(1, 0, 9'h010, 4'b0000, 32'h0, n1, bAck);
    join
    checkOutput("grantCount", ackOwner.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("grantOrder%0d", i), (i < ackOwner.size()) ? ackOwner[i] : 99, expOrder[i]);
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
